// File: rtl/size_detect_sequencer.sv
// Frame-level sequencer for the CAN DLC size detector: bus-idle sync, SOF catch, detector arm/latch, body tracking to EOF.
// Optional watchdog compiled in with `define SEQ_TIMEOUT_EN; otherwise errTimeout is tied low.
module size_detect_sequencer #(
  parameter int          IDLE_BITS    = 11,
  parameter int          TAIL_BITS    = 15,
  parameter int          TIMEOUT_BITS = 160,
  parameter logic [15:0] COUNT_INIT   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dIn,
  input  logic        bitTick,
  input  logic        sdComplete,
  input  logic [3:0]  sdMsgSize,
  output logic        sdResetN,
  output logic        sdEnable,
  output logic        frameActive,
  output logic        frameDone,
  output logic [3:0]  msgSize,
  output logic [3:0]  payloadBytes,
  output logic [15:0] frameCount,
  output logic        errShort,
  output logic        errTimeout
);

  localparam int RUN_W = $clog2(IDLE_BITS + 1);
  localparam logic [RUN_W-1:0] IDLE_MAX = RUN_W'(IDLE_BITS);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_IDLE  = 3'd1,
    S_CLEAR = 3'd2,
    S_ARM   = 3'd3,
    S_LATCH = 3'd4,
    S_BODY  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] sync_cnt, sync_cnt_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [7:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       min_bits, min_bits_nxt;
  logic [3:0]       msg_size_nxt, payload_nxt;
  logic [15:0]      frame_count_nxt;
  logic             done_set, short_set;
  logic             timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // Payload bits plus CRC tail; 8*8+15 = 79 keeps this within 8 bits.
  function automatic logic [7:0] min_len(input logic [3:0] bytes);
    return {1'b0, bytes, 3'b000} + 8'(TAIL_BITS);
  endfunction

`ifdef SEQ_TIMEOUT_EN
  logic [8:0] wd_cnt, wd_nxt;

  always_comb begin
    wd_nxt      = wd_cnt;
    timeout_hit = 1'b0;
    if (state == S_CLEAR) begin
      wd_nxt = '0;
    end else if ((state == S_ARM || state == S_BODY) && bitTick) begin
      wd_nxt      = wd_cnt + 9'd1;
      timeout_hit = (wd_cnt + 9'd1 == 9'(TIMEOUT_BITS));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt     <= '0;
      errTimeout <= 1'b0;
    end else begin
      wd_cnt     <= enable ? wd_nxt : '0;
      errTimeout <= enable & timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign errTimeout  = 1'b0;
`endif

  // enable and the watchdog override every state transition.
  always_comb begin
    state_nxt       = state;
    sync_cnt_nxt    = sync_cnt;
    run_cnt_nxt     = run_cnt;
    bit_cnt_nxt     = bit_cnt;
    min_bits_nxt    = min_bits;
    msg_size_nxt    = msgSize;
    payload_nxt     = payloadBytes;
    frame_count_nxt = frameCount;
    done_set        = 1'b0;
    short_set       = 1'b0;
    if (!enable) begin
      state_nxt    = S_SYNC;
      sync_cnt_nxt = '0;
    end else if (timeout_hit) begin
      state_nxt    = S_SYNC;
      sync_cnt_nxt = '0;
    end else begin
      case (state)
        S_SYNC: begin
          if (bitTick) begin
            if (!dIn) begin
              sync_cnt_nxt = '0;
            end else if (sync_cnt == IDLE_MAX - RUN_W'(1)) begin
              sync_cnt_nxt = '0;
              state_nxt    = S_IDLE;
            end else begin
              sync_cnt_nxt = sync_cnt + RUN_W'(1);
            end
          end
        end
        // Hard-sync: any dominant level starts a frame, tick or not.
        S_IDLE:  if (!dIn) state_nxt = S_CLEAR;
        S_CLEAR: state_nxt = S_ARM;
        S_ARM:   if (sdComplete) state_nxt = S_LATCH;
        S_LATCH: begin
          msg_size_nxt = sdMsgSize;
          payload_nxt  = clamp_dlc(sdMsgSize);
          min_bits_nxt = min_len(clamp_dlc(sdMsgSize));
          bit_cnt_nxt  = bitTick ? 8'd1 : 8'd0;
          run_cnt_nxt  = (bitTick && dIn) ? RUN_W'(1) : '0;
          state_nxt    = S_BODY;
        end
        S_BODY: begin
          if (bitTick) begin
            bit_cnt_nxt = sat_inc8(bit_cnt);
            if (!dIn) begin
              run_cnt_nxt = '0;
            end else begin
              run_cnt_nxt = run_cnt + RUN_W'(1);
              if (run_cnt_nxt == IDLE_MAX) begin
                if (bit_cnt_nxt >= min_bits) begin
                  state_nxt = S_DONE;
                end else begin
                  short_set = 1'b1;
                  state_nxt = S_IDLE;
                end
              end
            end
          end
        end
        S_DONE: begin
          done_set        = 1'b1;
          frame_count_nxt = frameCount + 16'd1;
          state_nxt       = S_IDLE;
        end
        default: state_nxt = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_SYNC;
      sync_cnt     <= '0;
      run_cnt      <= '0;
      bit_cnt      <= '0;
      min_bits     <= '0;
      msgSize      <= '0;
      payloadBytes <= '0;
      frameCount   <= COUNT_INIT;
      frameDone    <= 1'b0;
      errShort     <= 1'b0;
    end else begin
      state        <= state_nxt;
      sync_cnt     <= sync_cnt_nxt;
      run_cnt      <= run_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      min_bits     <= min_bits_nxt;
      msgSize      <= msg_size_nxt;
      payloadBytes <= payload_nxt;
      frameCount   <= frame_count_nxt;
      frameDone    <= done_set;
      errShort     <= short_set;
    end
  end

  assign sdResetN    = !(state inside {S_SYNC, S_IDLE, S_CLEAR});
  assign sdEnable    = state inside {S_ARM, S_LATCH, S_BODY, S_DONE};
  assign frameActive = state inside {S_CLEAR, S_ARM, S_LATCH, S_BODY, S_DONE};

endmodule

// File: tb/tb_size_detect_sequencer.sv
// Scoreboarded bench for size_detect_sequencer: directed frames, pulse events checked by a separate monitor.
module tb_size_detect_sequencer;

  logic        clk, reset, enable, dIn, bitTick, sdComplete;
  logic [3:0]  sdMsgSize;
  logic        sdResetN, sdEnable, frameActive, frameDone, errShort, errTimeout;
  logic [3:0]  msgSize, payloadBytes;
  logic [15:0] frameCount;
  logic        w_sdResetN, w_sdEnable, w_frameActive, w_frameDone, w_errShort, w_errTimeout;
  logic [3:0]  w_msgSize, w_payloadBytes;
  logic [15:0] w_frameCount;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [2:0]  kind;   // {frameDone, errShort, errTimeout}
    logic [3:0]  msg;
    logic [3:0]  pay;
    logic [15:0] cnt;
    logic [15:0] wcnt;
  } ev_t;

  ev_t q[$];

  size_detect_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .dIn(dIn), .bitTick(bitTick),
    .sdComplete(sdComplete), .sdMsgSize(sdMsgSize), .sdResetN(sdResetN),
    .sdEnable(sdEnable), .frameActive(frameActive), .frameDone(frameDone),
    .msgSize(msgSize), .payloadBytes(payloadBytes), .frameCount(frameCount),
    .errShort(errShort), .errTimeout(errTimeout)
  );

  // Same stimulus, frame counter starting at 0xFFFF to observe the wrap.
  size_detect_sequencer #(.COUNT_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .dIn(dIn), .bitTick(bitTick),
    .sdComplete(sdComplete), .sdMsgSize(sdMsgSize), .sdResetN(w_sdResetN),
    .sdEnable(w_sdEnable), .frameActive(w_frameActive), .frameDone(w_frameDone),
    .msgSize(w_msgSize), .payloadBytes(w_payloadBytes), .frameCount(w_frameCount),
    .errShort(w_errShort), .errTimeout(w_errTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [3:0] msg, input logic [3:0] pay,
                         input logic [15:0] cnt, input logic [15:0] wcnt);
    ev_t e;
    e.kind = kind; e.msg = msg; e.pay = pay; e.cnt = cnt; e.wcnt = wcnt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (frameDone || errShort || errTimeout)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {13'd0, frameDone, errShort, errTimeout}, 16'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {13'd0, frameDone, errShort, errTimeout}, {13'd0, e.kind});
        chk("pulse_msg", 16'(msgSize), 16'(e.msg));
        chk("pulse_pay", 16'(payloadBytes), 16'(e.pay));
        chk("pulse_count", frameCount, e.cnt);
        if (e.kind == 3'b100) chk("wrap_count", w_frameCount, e.wcnt);
      end
    end
  end

  task automatic tick(input logic d);
    dIn = d; bitTick = 1'b1;
    @(posedge clk); #1;
    bitTick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tail(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Alternating body bits ending dominant so no recessive run builds up.
  task automatic body(input int n);
    for (int i = 0; i < n; i++) tick(((n - 1 - i) % 2) != 0 ? 1'b1 : 1'b0);
  endtask

  task automatic sof();
    dIn = 1'b0;
    @(posedge clk); #1;
    chk("clear_active", 16'(frameActive), 16'd1);
    chk("clear_sdresetn", 16'(sdResetN), 16'd0);
    chk("clear_sdenable", 16'(sdEnable), 16'd0);
    @(posedge clk); #1;
    chk("arm_sdenable", 16'(sdEnable), 16'd1);
    chk("arm_sdresetn", 16'(sdResetN), 16'd1);
  endtask

  task automatic complete(input logic [3:0] dlc, input logic [3:0] pay);
    sdComplete = 1'b1; sdMsgSize = dlc;
    @(posedge clk); #1;
    sdComplete = 1'b0;
    @(posedge clk); #1;
    chk("latch_msg", 16'(msgSize), 16'(dlc));
    chk("latch_pay", 16'(payloadBytes), 16'(pay));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dIn = 1'b1; bitTick = 1'b0;
    sdComplete = 1'b0; sdMsgSize = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_sdresetn", 16'(sdResetN), 16'd0);
    chk("rst_sdenable", 16'(sdEnable), 16'd0);
    chk("rst_active", 16'(frameActive), 16'd0);
    chk("rst_done", 16'(frameDone), 16'd0);
    chk("rst_msg", 16'(msgSize), 16'd0);
    chk("rst_pay", 16'(payloadBytes), 16'd0);
    chk("rst_count", frameCount, 16'd0);
    chk("rst_short", 16'(errShort), 16'd0);
    chk("rst_timeout", 16'(errTimeout), 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;

    // Sync: a dominant tick restarts the idle count.
    tail(5); tick(1'b0); tail(10);
    dIn = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("sync_no_sof", 16'(frameActive), 16'd0);
    dIn = 1'b1;
    tick(1'b1);

    // A: DLC 2, minBits 31, 31 body + 11 idle; explicit EOF latency.
    sof(); complete(4'h2, 4'h2); body(31);
    push_ev(3'b100, 4'h2, 4'h2, 16'd1, 16'd0);
    tail(10);
    dIn = 1'b1; bitTick = 1'b1;
    @(posedge clk); #1;
    bitTick = 1'b0;
    chk("done_lat1", 16'(frameDone), 16'd0);
    chk("done_state_en", 16'(sdEnable), 16'd1);
    @(posedge clk); #1;
    chk("done_lat2", 16'(frameDone), 16'd1);
    chk("done_count", frameCount, 16'd1);
    chk("idle_sdenable", 16'(sdEnable), 16'd0);
    @(posedge clk); #1;

    // B: DLC 0xC -> payload 8, minBits 79; exactly 79 bits is valid.
    sof(); complete(4'hC, 4'h8); body(68);
    push_ev(3'b100, 4'hC, 4'h8, 16'd2, 16'd1);
    tail(11);

    // C: same DLC, 78 bits -> short.
    sof(); complete(4'hC, 4'h8); body(67);
    push_ev(3'b010, 4'hC, 4'h8, 16'd2, 16'd1);
    tail(11);

    // D: DLC 8, 40 body bits -> short, back to idle without re-sync.
    sof(); complete(4'h8, 4'h8); body(40);
    push_ev(3'b010, 4'h8, 4'h8, 16'd2, 16'd1);
    tail(11);

    // E: abandoned by enable drop mid-body.
    sof(); complete(4'h3, 4'h3); body(10);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abandon_sdresetn", 16'(sdResetN), 16'd0);
    chk("abandon_active", 16'(frameActive), 16'd0);
    chk("abandon_msg", 16'(msgSize), 16'd3);
    chk("abandon_count", frameCount, 16'd2);
    enable = 1'b1;
    tail(11);

    // F: DLC 0, minBits 15, exactly 15 bits.
    sof(); complete(4'h0, 4'h0); body(4);
    push_ev(3'b100, 4'h0, 4'h0, 16'd3, 16'd2);
    tail(11);

    // G: detector never completes.
    sof();
    for (int i = 0; i < 159; i++) tick(1'b1);
`ifdef SEQ_TIMEOUT_EN
    push_ev(3'b001, 4'h0, 4'h0, 16'd3, 16'd2);
`endif
    dIn = 1'b1; bitTick = 1'b1;
    @(posedge clk); #1;
    bitTick = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_pulse", 16'(errTimeout), 16'd1);
    chk("timeout_sdresetn", 16'(sdResetN), 16'd0);
`else
    chk("no_timeout", 16'(errTimeout), 16'd0);
    chk("stuck_arm", 16'(sdEnable), 16'd1);
`endif
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    tail(11);

    // Asynchronous reset mid-body.
    sof(); complete(4'h5, 4'h5); body(3);
    #2 reset = 1'b1;
    #1;
    chk("areset_sdresetn", 16'(sdResetN), 16'd0);
    chk("areset_sdenable", 16'(sdEnable), 16'd0);
    chk("areset_active", 16'(frameActive), 16'd0);
    chk("areset_msg", 16'(msgSize), 16'd0);
    chk("areset_count", frameCount, 16'd0);
    chk("events_left", 16'(q.size()), 16'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/size_detect_sequencer.md
# size_detect_sequencer

Frame-level controller for the DLC size detector in the CAN timing-analysis channel unit. It waits for bus idle and catches the start-of-frame (SOF) edge. It then clears and arms the size detector and latches the DLC when the detector reports completion. Finally, it tracks the frame body to end-of-frame before re-arming. It sits between the bit-timing front end (synchronized bus value plus sample-point tick) and the size detector, and feeds frame statistics to the capture logic.

## Interface
- IDLE_BITS, 11, consecutive recessive sampled bits that define bus idle / end of frame
- TAIL_BITS, 15, minimum bits (CRC field) required after the payload before end-of-frame is accepted
- TIMEOUT_BITS, 160, watchdog limit in bit ticks while a frame is in progress
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  sequencer run enable
- dIn  in  1  synchronized CAN bus value (0 = dominant)
- bitTick  in  1  one-cycle pulse at each bit's final sample point
- sdComplete  in  1  size detector's completeConfig
- sdMsgSize  in  4  size detector's msgSize
- sdResetN  out  1  synchronous active-low clear to size detector
- sdEnable  out  1  size detector enable
- frameActive  out  1  high from SOF through end-of-frame
- frameDone  out  1  one-cycle pulse on a valid frame end
- msgSize  out  4  latched DLC of the last frame
- payloadBytes  out  4  min(msgSize, 8)
- frameCount  out  16  valid frames seen, wraps 0xFFFF→0
- errShort  out  1  one-cycle pulse: frame ended before minimum length
- errTimeout  out  1  one-cycle pulse: watchdog expiry (0 when compiled out)

## Operation
- Reset values:
  - sdResetN=0, all other outputs 0.
  - State S_SYNC; all counters 0.
- States and transitions:
  - S_SYNC:
    - Count bitTicks with dIn=1; a tick with dIn=0 clears the count.
    - Count reaching IDLE_BITS → S_IDLE.
  - S_IDLE: dIn=0 on any cycle (hard-sync edge, not gated by bitTick) → S_CLEAR.
  - S_CLEAR: one cycle, then → S_ARM.
  - S_ARM: sdComplete=1 → S_LATCH.
  - S_LATCH: one cycle.
    - msgSize←sdMsgSize.
    - payloadBytes←(sdMsgSize>8 ? 8 : sdMsgSize).
    - minBits←8·payloadBytes+TAIL_BITS (8-bit, max 79).
    - bitCnt and runCnt cleared. A bitTick in this cycle is counted as the first body bit.
  - S_BODY: per bitTick:
    - bitCnt increments, saturating at 255.
    - runCnt increments if dIn=1, else clears.
    - When runCnt reaches IDLE_BITS → S_DONE if bitCnt ≥ minBits, else pulse errShort and → S_IDLE.
  - S_DONE: one cycle; frameDone=1, frameCount+1, → S_IDLE. The bus is already idle, so no re-sync is needed.
- Output decode:
  - sdResetN=0 in S_SYNC, S_IDLE, S_CLEAR; 1 in all other states.
  - sdEnable=1 in S_ARM, S_LATCH, S_BODY, S_DONE.
  - frameActive=1 in S_CLEAR through S_DONE.
- enable=0 in any state:
  - → S_SYNC on the next clock.
  - The frame in progress is abandoned with no frameDone or error pulse.
  - msgSize and frameCount hold their values.
- msgSize and payloadBytes hold until the next S_LATCH.

## Timing
- SOF edge to sdEnable=1: 2 cycles (S_CLEAR, then S_ARM). The front end guarantees the SOF sample point is ≥3 cycles after the edge, so the size detector samples SOF itself.
- sdComplete to msgSize valid: 2 cycles (S_LATCH registers it; visible the following cycle).
- Final idle bitTick to frameDone: 2 cycles (transition into S_DONE, then pulse).
- Simultaneous events:
  - enable=0 has priority over every transition, including timeout.
  - Timeout has priority over end-of-frame in the same cycle.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately, including sdResetN=0, so the size detector is held in reset.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A 9-bit watchdog counts bitTicks in S_ARM and S_BODY and clears on entry to S_ARM.
  - On reaching TIMEOUT_BITS it pulses errTimeout for one cycle and forces → S_SYNC.
- SEQ_TIMEOUT_EN undefined:
  - No watchdog is built and errTimeout is tied to 0.
  - A frame whose detector never completes stalls in S_ARM until enable is deasserted or reset is applied.

## Test plan
- Reset, enable=1, 11 recessive ticks, then dIn falls → sdResetN low through S_CLEAR; sdEnable=1 exactly 2 cycles after the edge.
- sdComplete with sdMsgSize=4'hC → msgSize=0xC, payloadBytes=8, minBits=79.
- DLC=2, 31 body bits, then 11 recessive ticks → frameDone pulses once and frameCount goes 0→1.
- DLC=8 and the bus goes idle after 40 body bits → errShort pulses, no frameDone, state returns to S_IDLE.
- With SEQ_TIMEOUT_EN, sdComplete held low for 160 ticks → errTimeout pulses and sdResetN=0 the next cycle. Without the macro, errTimeout stays 0 and the sequencer remains in S_ARM.
- enable dropped mid-body, then frameCount preloaded at 0xFFFF and a valid frame run → no pulses on the abandoned frame; the valid frame wraps frameCount to 0x0000.
